fmac_apb_driver: RTL and testbench
==================================

Name: fmac_apb_driver

Overview:
- APB master that sits directly upstream of the APB FMAC slave and drives one fused multiply-add per accepted operand triple.
- Accepts a triple (A, B, C) on a valid/ready stream and performs the fixed APB programme: write A, write B, write C, write START, poll STATUS until not busy, read RESULT.
- Returns the 32-bit result on a valid/ready output stream, with a timeout error flag.

Parameters:
- ADDR_A, 5'h00, FMAC operand A register address
- ADDR_B, 5'h04, FMAC operand B register address
- ADDR_C, 5'h08, FMAC operand C register address
- ADDR_RES, 5'h0c, FMAC result register address
- ADDR_CTL, 5'h14, FMAC control/status register (write = start, read = status)
- BUSY_BIT, 0, bit index of the busy flag in the status word
- MAX_POLL, 16, maximum status reads before timeout (minimum 1)

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- in_valid  in  1  operand triple valid
- in_ready  out  1  driver can accept a triple
- in_a  in  32  operand A (IEEE-754 single)
- in_b  in  32  operand B
- in_c  in  32  operand C
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_res  out  32  result word read from ADDR_RES
- out_err  out  1  qualifies out_valid; 1 = poll timeout, out_res = last status word
- apb_paddr  out  5  APB address
- apb_psel  out  1  APB select
- apb_penable  out  1  APB enable
- apb_pwrite  out  1  APB direction, 1 = write
- apb_pwdata  out  32  APB write data
- apb_prdata  in  32  APB read data
- apb_pready  in  1  APB ready

Behaviour:
- Single clock, clk. Reset nrst is asynchronous and active-low.
- Reset values: all outputs 0 except in_ready = 1. FSM goes to IDLE, poll counter = 0, operand registers = 0.
- FSM states: IDLE, WR_A, WR_B, WR_C, WR_START, POLL, RD_RES, OUT.
- Each transfer state has two phases:
  - SETUP: psel = 1, penable = 0, exactly 1 cycle.
  - ACCESS: psel = 1, penable = 1, held until pready = 1.
- A transfer completes on the clk edge where psel & penable & pready are all 1.
- paddr, pwrite and pwdata are stable from SETUP through completion.
- Back-to-back transfers: the next state's SETUP starts the cycle after completion, with psel held high.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch in_a, in_b and in_c, then go to WR_A. in_ready drops the next cycle.
  - in_ready stays 0 until the FSM returns to IDLE; only one operation is in flight.
- WR_A, WR_B, WR_C: write the latched operand to ADDR_A, ADDR_B and ADDR_C respectively.
- WR_START: write 32'h0 to ADDR_CTL.
- POLL:
  - Read ADDR_CTL and sample prdata on completion.
  - prdata[BUSY_BIT] = 0: go to RD_RES.
  - Busy and fewer than MAX_POLL reads done: issue another read (new SETUP next cycle).
  - Busy on the MAX_POLL-th read: go to OUT with out_err = 1 and out_res = sampled status.
- RD_RES: read ADDR_RES, latch prdata into out_res with out_err = 0, go to OUT.
- OUT:
  - psel = 0 and out_valid = 1.
  - out_res and out_err are held stable while out_valid & !out_ready.
  - On out_valid & out_ready, go to IDLE; out_valid drops and in_ready rises the next cycle.
- Latency with pready tied to 1 and the first poll not busy:
  - 6 transfers × 2 cycles = 12 cycles.
  - out_valid rises 13 cycles after the in handshake edge.
  - Each extra pready-low cycle or extra poll adds latency one for one.
- Reset mid-operation: every output returns to its reset value immediately (psel may drop mid-transfer; this is accepted). The in-flight operation is discarded.
- pwdata is 0 during reads. The driver does not check pslverr (there is no such port).

Test Plan:
- Reset, then in_a=32'h401a_3237, in_b=32'h3eae_76d1, in_c=32'h3ee9_c749, pready=1, slave never busy:
  - APB writes go to 0x00, 0x04, 0x08, 0x14 (data 0), followed by a read of 0x14 and a read of 0x0c.
  - out_res equals the slave result, out_err=0, out_valid at cycle 13.
- Slave reports busy for 3 polls:
  - 4 reads of 0x14 occur before the read of 0x0c; latency is 19 cycles.
- Slave is always busy, MAX_POLL=16:
  - Exactly 16 status reads occur, then out_valid=1 with out_err=1 and out_res[BUSY_BIT]=1.
  - No read of 0x0c occurs.
- pready held low for 3 cycles on the WR_B access:
  - paddr=0x04, pwdata=in_b and penable=1 stay stable for 4 cycles.
  - Total latency is 16 cycles.
- out_ready held 0 for 5 cycles:
  - out_valid and out_res are stable and in_ready stays 0.
  - A second in_valid is not accepted until the cycle after the out handshake.
- nrst pulsed low during WR_C:
  - psel, penable and out_valid go to 0 asynchronously and in_ready goes to 1.
  - A new triple is then processed normally.

Source files
------------

// File: rtl/fmac_apb_driver.sv
// APB master that runs one fused multiply-add on the FMAC slave per accepted
// operand triple: write A, B, C, START, poll status, read result.
module fmac_apb_driver #(
  parameter logic [4:0] ADDR_A   = 5'h00,
  parameter logic [4:0] ADDR_B   = 5'h04,
  parameter logic [4:0] ADDR_C   = 5'h08,
  parameter logic [4:0] ADDR_RES = 5'h0c,
  parameter logic [4:0] ADDR_CTL = 5'h14,
  parameter int         BUSY_BIT = 0,
  parameter int         MAX_POLL = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic        out_err,
  output logic [4:0]  apb_paddr,
  output logic        apb_psel,
  output logic        apb_penable,
  output logic        apb_pwrite,
  output logic [31:0] apb_pwdata,
  input  logic [31:0] apb_prdata,
  input  logic        apb_pready
);

  localparam int PW = $clog2(MAX_POLL + 1);
  localparam logic [PW:0] POLL_LIMIT = (PW + 1)'(MAX_POLL);

  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, WR_C, WR_START, POLL, RD_RES, OUT
  } state_t;

  state_t        state_reg, state_next;
  logic          access_reg, access_next;
  logic [PW-1:0] poll_cnt_reg, poll_cnt_next;
  logic [PW:0]   poll_inc;
  logic [31:0]   a_reg, b_reg, c_reg;
  logic [31:0]   res_reg, res_next;
  logic          err_reg, err_next;
  logic          in_fire;
  logic          xfer;
  logic          done;

  assign in_fire  = in_valid && (state_reg == IDLE);
  assign xfer     = (state_reg != IDLE) && (state_reg != OUT);
  assign done     = xfer && access_reg && apb_pready;
  assign poll_inc = {1'b0, poll_cnt_reg} + {{PW{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg    <= IDLE;
      access_reg   <= 1'b0;
      poll_cnt_reg <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      c_reg        <= '0;
      res_reg      <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      access_reg   <= access_next;
      poll_cnt_reg <= poll_cnt_next;
      res_reg      <= res_next;
      err_reg      <= err_next;
      if (in_fire) begin
        a_reg <= in_a;
        b_reg <= in_b;
        c_reg <= in_c;
      end
    end
  end

  // access_reg selects SETUP (0) or ACCESS (1) within every transfer state
  always_comb begin
    state_next    = state_reg;
    access_next   = access_reg;
    poll_cnt_next = poll_cnt_reg;
    res_next      = res_reg;
    err_next      = err_reg;
    if (xfer && !access_reg) access_next = 1'b1;
    if (done)                access_next = 1'b0;
    case (state_reg)
      IDLE:     if (in_valid) state_next = WR_A;
      WR_A:     if (done) state_next = WR_B;
      WR_B:     if (done) state_next = WR_C;
      WR_C:     if (done) state_next = WR_START;
      WR_START: begin
        if (done) begin
          state_next    = POLL;
          poll_cnt_next = '0;
        end
      end
      POLL: begin
        if (done) begin
          poll_cnt_next = poll_inc[PW-1:0];
          if (!apb_prdata[BUSY_BIT]) begin
            state_next = RD_RES;
          end else if (poll_inc >= POLL_LIMIT) begin
            state_next = OUT;
            res_next   = apb_prdata;
            err_next   = 1'b1;
          end
        end
      end
      RD_RES: begin
        if (done) begin
          state_next = OUT;
          res_next   = apb_prdata;
          err_next   = 1'b0;
        end
      end
      OUT:      if (out_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    apb_paddr  = '0;
    apb_pwrite = 1'b0;
    apb_pwdata = '0;
    case (state_reg)
      WR_A: begin
        apb_paddr  = ADDR_A;
        apb_pwrite = 1'b1;
        apb_pwdata = a_reg;
      end
      WR_B: begin
        apb_paddr  = ADDR_B;
        apb_pwrite = 1'b1;
        apb_pwdata = b_reg;
      end
      WR_C: begin
        apb_paddr  = ADDR_C;
        apb_pwrite = 1'b1;
        apb_pwdata = c_reg;
      end
      WR_START: begin
        apb_paddr  = ADDR_CTL;
        apb_pwrite = 1'b1;
      end
      POLL:    apb_paddr = ADDR_CTL;
      RD_RES:  apb_paddr = ADDR_RES;
      default: apb_paddr = '0;
    endcase
  end

  assign apb_psel    = xfer;
  assign apb_penable = xfer && access_reg;
  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == OUT);
  assign out_res     = res_reg;
  assign out_err     = err_reg;

endmodule

// File: tb/tb_fmac_apb_driver.sv
// Bench for fmac_apb_driver: APB slave model plus a scoreboard that predicts
// the transfer programme, result and latency of every accepted triple.
module tb_fmac_apb_driver;

  localparam int          MAX_POLL    = 16;
  localparam logic [31:0] STATUS_BUSY = 32'h5a5a_0001;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0, in_c = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_res;
  logic        out_err;
  logic [4:0]  apb_paddr;
  logic        apb_psel, apb_penable, apb_pwrite;
  logic [31:0] apb_pwdata;
  logic [31:0] apb_prdata = '0;
  logic        apb_pready = 1'b1;

  fmac_apb_driver dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_err(out_err),
    .apb_paddr(apb_paddr), .apb_psel(apb_psel), .apb_penable(apb_penable),
    .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata),
    .apb_prdata(apb_prdata), .apb_pready(apb_pready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // slave configuration, written by the stimulus only
  int          cfg_busy = 0;
  bit          cfg_always = 1'b0;
  int          cfg_stall = 0;
  logic [4:0]  cfg_stall_addr = 5'h04;
  logic [31:0] cfg_result = '0;

  typedef struct packed {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
  } xfer_t;

  xfer_t       exp_q[$];
  int          cyc = 0;
  bit          inflight = 1'b0;
  bit          first_valid = 1'b0;
  int          start_cyc = 0, exp_lat = 0, lat_last = 0;
  logic [31:0] exp_res = '0, last_res = '0, slave_res = '0;
  logic        exp_err = 1'b0, last_err = 1'b0;
  int          busy_left = 0, stall_left = 0;
  bit          always_busy = 1'b0;
  logic [4:0]  stall_addr = '0;
  int          n_status = 0, n_result = 0, b_len = 0, acc_len = 0;
  int          done_cnt = 0, last_out_cyc = 0, accept_gap = 0;
  bit          prev_setup = 1'b0;
  logic [4:0]  s_addr = '0;
  logic        s_w = 1'b0;
  logic [31:0] s_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit    pr, busy, tmo;
    int    nstat;
    xfer_t x;
    if (!nrst) begin
      exp_q.delete();
      inflight   = 1'b0;
      prev_setup = 1'b0;
      apb_pready = 1'b1;
      apb_prdata = '0;
    end else begin
      // slave: decide pready and read data for the coming edge
      pr = 1'b1;
      if (apb_psel && apb_penable && stall_left > 0 && apb_paddr == stall_addr) begin
        pr = 1'b0;
        stall_left--;
      end
      apb_pready = pr;
      apb_prdata = '0;
      if (prev_setup) chk("setup_then_access", int'(apb_psel && apb_penable), 1);
      if (apb_penable) begin
        chk("penable_needs_psel", int'(apb_psel), 1);
        chk32("paddr_stable", 32'(apb_paddr), 32'(s_addr));
        chk("pwrite_stable", int'(apb_pwrite), int'(s_w));
        chk32("pwdata_stable", apb_pwdata, s_data);
        acc_len++;
      end
      if (apb_psel && !apb_penable) begin
        s_addr  = apb_paddr;
        s_w     = apb_pwrite;
        s_data  = apb_pwdata;
        acc_len = 0;
        if (!apb_pwrite) chk32("pwdata_zero_on_read", apb_pwdata, 32'h0);
      end
      prev_setup = apb_psel && !apb_penable;
      if (apb_psel && apb_penable && pr) begin
        if (!apb_pwrite && apb_paddr == 5'h14) begin
          busy = always_busy || busy_left > 0;
          if (busy_left > 0) busy_left--;
          apb_prdata = busy ? STATUS_BUSY : 32'h0;
          n_status++;
        end else if (!apb_pwrite && apb_paddr == 5'h0c) begin
          apb_prdata = slave_res;
          n_result++;
        end
        if (apb_pwrite && apb_paddr == 5'h04) b_len = acc_len;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer addr=%h required no transfer", apb_paddr);
        end else begin
          x = exp_q.pop_front();
          chk32("xfer_addr", 32'(apb_paddr), 32'(x.a));
          chk("xfer_dir", int'(apb_pwrite), int'(x.w));
          if (x.w) chk32("xfer_wdata", apb_pwdata, x.d);
        end
      end
      // output side
      if (out_valid) begin
        chk("in_ready_low_at_out", int'(in_ready), 0);
        chk("apb_idle_at_out", int'(apb_psel), 0);
        chk32("out_res", out_res, exp_res);
        chk("out_err", int'(out_err), int'(exp_err));
        if (first_valid) begin
          lat_last = cyc - start_cyc;
          chk("latency", lat_last, exp_lat);
          first_valid = 1'b0;
        end
        if (out_ready) begin
          chk("all_xfers_done", exp_q.size(), 0);
          inflight     = 1'b0;
          last_res     = out_res;
          last_err     = out_err;
          last_out_cyc = cyc;
          done_cnt++;
        end
      end else if (inflight) begin
        chk("in_ready_low_busy", int'(in_ready), 0);
      end
      // input side: predict the whole programme for this triple
      if (in_valid && in_ready) begin
        chk("single_inflight", int'(inflight), 0);
        accept_gap  = cyc - last_out_cyc;
        busy_left   = cfg_busy;
        always_busy = cfg_always;
        stall_left  = cfg_stall;
        stall_addr  = cfg_stall_addr;
        slave_res   = cfg_result;
        tmo   = cfg_always || cfg_busy >= MAX_POLL;
        nstat = tmo ? MAX_POLL : cfg_busy + 1;
        exp_q.push_back('{1'b1, 5'h00, in_a});
        exp_q.push_back('{1'b1, 5'h04, in_b});
        exp_q.push_back('{1'b1, 5'h08, in_c});
        exp_q.push_back('{1'b1, 5'h14, 32'h0});
        for (int i = 0; i < nstat; i++) exp_q.push_back('{1'b0, 5'h14, 32'h0});
        if (!tmo) exp_q.push_back('{1'b0, 5'h0c, 32'h0});
        exp_res     = tmo ? STATUS_BUSY : cfg_result;
        exp_err     = tmo;
        exp_lat     = 2 * (4 + nstat + (tmo ? 0 : 1)) + cfg_stall + 1;
        start_cyc   = cyc;
        n_status    = 0;
        n_result    = 0;
        first_valid = 1'b1;
        inflight    = 1'b1;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    int t;
    in_a = a;
    in_b = b;
    in_c = c;
    in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 300);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=0 required 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while (done_cnt < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt < n) begin
      checks++;
      errors++;
      $display("FAIL done_timeout completed=%0d required %0d", done_cnt, n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_psel_penable", int'({apb_psel, apb_penable, apb_pwrite, out_err}), 0);
    chk32("rst_paddr", 32'(apb_paddr), 32'h0);
    chk32("rst_pwdata", apb_pwdata, 32'h0);
    chk32("rst_out_res", out_res, 32'h0);
    #11 nrst = 1'b1;
    @(posedge clk);
    #1;

    // nominal: never busy, pready tied high
    cfg_result = 32'h3fd7_a9b2;
    send(32'h401a_3237, 32'h3eae_76d1, 32'h3ee9_c749);
    wait_done(1);
    chk("lat_basic", lat_last, 13);
    chk("status_reads_basic", n_status, 1);
    chk32("res_basic", last_res, 32'h3fd7_a9b2);

    // three busy polls
    cfg_busy   = 3;
    cfg_result = 32'h4049_0fdb;
    send(32'h3f80_0000, 32'h4000_0000, 32'h4040_0000);
    wait_done(2);
    chk("lat_busy3", lat_last, 19);
    chk("status_reads_busy3", n_status, 4);
    chk("result_reads_busy3", n_result, 1);

    // always busy: timeout after MAX_POLL status reads
    cfg_busy   = 0;
    cfg_always = 1'b1;
    send(32'hc000_0000, 32'h3f00_0000, 32'h0000_0000);
    wait_done(3);
    cfg_always = 1'b0;
    chk("status_reads_timeout", n_status, 16);
    chk("result_reads_timeout", n_result, 0);
    chk("err_timeout", int'(last_err), 1);
    chk("busy_bit_timeout", int'(last_res[0]), 1);
    chk("lat_timeout", lat_last, 41);

    // pready low for 3 cycles on the WR_B access
    cfg_stall      = 3;
    cfg_stall_addr = 5'h04;
    cfg_result     = 32'hbf80_0000;
    send(32'h1111_2222, 32'h3333_4444, 32'h5555_6666);
    wait_done(4);
    cfg_stall = 0;
    chk("lat_stall", lat_last, 16);
    chk("wr_b_access_len", b_len, 4);

    // consumer stalls; a second triple waits on the input
    out_ready  = 1'b0;
    cfg_result = 32'h0bad_cafe;
    send(32'h0102_0304, 32'h0506_0708, 32'h090a_0b0c);
    in_a = 32'haaaa_0001;
    in_b = 32'hbbbb_0002;
    in_c = 32'hcccc_0003;
    in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 100);
    chk("hold_reached_out", int'(out_valid), 1);
    repeat (4) begin
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk32("hold_res", out_res, 32'h0bad_cafe);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 20);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done(6);
    chk("accept_gap", accept_gap, 1);
    chk("lat_second", lat_last, 13);

    // asynchronous reset during WR_C
    send(32'hdead_0001, 32'hdead_0002, 32'hdead_0003);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(apb_psel && apb_paddr == 5'h08) && t < 20);
    chk("reached_wr_c", int'(apb_psel && apb_paddr == 5'h08), 1);
    #1 nrst = 1'b0;
    #1;
    chk("arst_psel", int'(apb_psel), 0);
    chk("arst_penable", int'(apb_penable), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    @(posedge clk);
    #1 nrst = 1'b1;
    cfg_result = 32'h4120_0000;
    send(32'h3f80_0000, 32'h4110_0000, 32'h3f80_0000);
    wait_done(7);
    chk("lat_after_reset", lat_last, 13);
    chk32("res_after_reset", last_res, 32'h4120_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
